// File: rtl/heichips25_pkg.sv
// heichips25_pkg: FSM state type and pad-width constants shared by the project mux
// and its slice selector.
package heichips25_pkg;
   typedef enum logic [1:0] {IDLE, DRAIN, HOLD, RUN} state_t;
   localparam int PAD_W    = 8;
   localparam int MAX_PROJ = 16;
endpackage

// File: rtl/heichips25_proj_mux_sel.sv
// heichips25_proj_mux_sel: one-of-N selector picking the 8-bit slice of i_bus addressed by i_sel.
module heichips25_proj_mux_sel
   import heichips25_pkg::*;
#(
   parameter int NUM_PROJ = 4,
   parameter int SEL_W    = 4
) (
   input  logic [NUM_PROJ*PAD_W-1:0] i_bus,
   input  logic [SEL_W-1:0]          i_sel,
   output logic [PAD_W-1:0]          o_slice
);
   always_comb begin
      o_slice = '0;
      for (int i = 0; i < NUM_PROJ; i++)
         if (i_sel == SEL_W'(i)) o_slice = i_bus[i*PAD_W +: PAD_W];
   end
endmodule

// File: rtl/heichips25_proj_mux.sv
// heichips25_proj_mux: shares one pad set between NUM_PROJ projects with an isolate/reset/connect
// hand-over. Define HEICHIPS25_PROJ_MUX_ISOLATE_EN to zero pad inputs for unselected projects.
module heichips25_proj_mux
   import heichips25_pkg::*;
#(
   parameter int NUM_PROJ = 4,
   parameter int SEL_W    = 4,
   parameter int RST_HOLD = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   input  logic [PAD_W-1:0]          ui_in,
   output logic [PAD_W-1:0]          uo_out,
   input  logic [PAD_W-1:0]          uio_in,
   output logic [PAD_W-1:0]          uio_out,
   output logic [PAD_W-1:0]          uio_oe,
   input  logic                      sel_valid,
   input  logic [SEL_W-1:0]          sel_id,
   output logic                      sel_ready,
   output logic [NUM_PROJ*PAD_W-1:0] proj_ui_in,
   output logic [NUM_PROJ*PAD_W-1:0] proj_uio_in,
   input  logic [NUM_PROJ*PAD_W-1:0] proj_uo_out,
   input  logic [NUM_PROJ*PAD_W-1:0] proj_uio_out,
   input  logic [NUM_PROJ*PAD_W-1:0] proj_uio_oe,
   output logic [NUM_PROJ-1:0]       proj_ena,
   output logic [NUM_PROJ-1:0]       proj_rst_n,
   output logic [SEL_W-1:0]          active_id,
   output logic                      busy,
   output logic                      sel_err
);
   state_t           r_state;
   logic [7:0]       r_cnt;
   logic [SEL_W-1:0] r_active_id;
   logic             r_sel_err;
   logic [PAD_W-1:0] r_uo, r_uio_out, r_uio_oe;
   logic [PAD_W-1:0] w_uo, w_uio_out, w_uio_oe;
   logic             w_accept, w_run, w_live, w_load;

   assign w_run     = r_state == RUN;
   assign w_live    = r_state == HOLD || w_run;
   assign sel_ready = r_state == IDLE || w_run;
   assign busy      = !sel_ready;
   assign w_accept  = sel_valid && sel_ready;
   // Pads are released the same edge a new command is taken, so DRAIN already sees inputs only.
   assign w_load    = w_run && !w_accept;
   assign active_id = r_active_id;
   assign sel_err   = r_sel_err;
   assign uo_out    = r_uo;
   assign uio_out   = r_uio_out;
   assign uio_oe    = r_uio_oe;

   heichips25_proj_mux_sel #(.NUM_PROJ(NUM_PROJ), .SEL_W(SEL_W)) u_sel_uo
      (.i_bus(proj_uo_out), .i_sel(r_active_id), .o_slice(w_uo));
   heichips25_proj_mux_sel #(.NUM_PROJ(NUM_PROJ), .SEL_W(SEL_W)) u_sel_uio_out
      (.i_bus(proj_uio_out), .i_sel(r_active_id), .o_slice(w_uio_out));
   heichips25_proj_mux_sel #(.NUM_PROJ(NUM_PROJ), .SEL_W(SEL_W)) u_sel_uio_oe
      (.i_bus(proj_uio_oe), .i_sel(r_active_id), .o_slice(w_uio_oe));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_active_id <= '0;
         r_sel_err   <= 1'b0;
         r_uo        <= '0;
         r_uio_out   <= '0;
         r_uio_oe    <= '0;
      end else begin
         case (r_state)
            IDLE, RUN: if (w_accept) r_state <= DRAIN;
            DRAIN: begin
               r_state <= r_sel_err ? IDLE : HOLD;
               r_cnt   <= 8'(RST_HOLD - 1);
            end
            default: if (r_cnt == 8'd0) r_state <= RUN; else r_cnt <= r_cnt - 8'd1;
         endcase
         if (w_accept) begin
            r_active_id <= sel_id;
            r_sel_err   <= 32'(sel_id) >= NUM_PROJ;
         end
         r_uo      <= w_load ? w_uo : '0;
         r_uio_out <= w_load ? w_uio_out : '0;
         r_uio_oe  <= w_load ? w_uio_oe : '0;
      end
   end

   for (genvar i = 0; i < NUM_PROJ; i++) begin : g_proj
      logic w_hit;
      assign w_hit         = r_active_id == SEL_W'(i);
      assign proj_ena[i]   = ena & w_hit & w_live;
      assign proj_rst_n[i] = w_hit & w_run;
`ifdef HEICHIPS25_PROJ_MUX_ISOLATE_EN
      assign proj_ui_in[i*PAD_W +: PAD_W]  = (w_hit && w_live) ? ui_in : '0;
      assign proj_uio_in[i*PAD_W +: PAD_W] = (w_hit && w_live) ? uio_in : '0;
`else
      assign proj_ui_in[i*PAD_W +: PAD_W]  = ui_in;
      assign proj_uio_in[i*PAD_W +: PAD_W] = uio_in;
`endif
   end
endmodule

// File: tb/tb_heichips25_proj_mux.sv
// tb_heichips25_proj_mux: randomized scenario bench for the project mux against a
// behavioural hand-over model (DRAIN 1 cycle, HOLD RST_HOLD cycles, then RUN).
module tb_heichips25_proj_mux;
   localparam int NP = 4;
   localparam int SW = 4;
   localparam int RH = 8;
   localparam int PW = NP * 8;
`ifdef HEICHIPS25_PROJ_MUX_ISOLATE_EN
   localparam bit ISO = 1'b1;
`else
   localparam bit ISO = 1'b0;
`endif

   logic          clk = 1'b0, rst_n = 1'b0, ena = 1'b1, sel_valid = 1'b0;
   logic [7:0]    ui_in = '0, uio_in = '0;
   logic [SW-1:0] sel_id = '0;
   logic [PW-1:0] proj_uo_out = '0, proj_uio_out = '0, proj_uio_oe = '0;
   logic [7:0]    uo_out, uio_out, uio_oe;
   logic          sel_ready, busy, sel_err;
   logic [PW-1:0] proj_ui_in, proj_uio_in;
   logic [NP-1:0] proj_ena, proj_rst_n;
   logic [SW-1:0] active_id;
   int total = 0, bad = 0;
   int m_id = 0;

   heichips25_proj_mux #(.NUM_PROJ(NP), .SEL_W(SW), .RST_HOLD(RH)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in),
      .uio_out(uio_out), .uio_oe(uio_oe), .sel_valid(sel_valid), .sel_id(sel_id),
      .sel_ready(sel_ready), .proj_ui_in(proj_ui_in), .proj_uio_in(proj_uio_in),
      .proj_uo_out(proj_uo_out), .proj_uio_out(proj_uio_out), .proj_uio_oe(proj_uio_oe),
      .proj_ena(proj_ena), .proj_rst_n(proj_rst_n), .active_id(active_id), .busy(busy),
      .sel_err(sel_err));

   always #5 clk = ~clk;

   function automatic logic [7:0] slice(input logic [PW-1:0] v, input int id);
      return 8'(v >> (8 * id));
   endfunction

   function automatic logic [NP-1:0] onehot(input int id);
      return NP'(1) << id;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shuffle();
      proj_uo_out  = PW'($urandom);
      proj_uio_out = PW'($urandom);
      proj_uio_oe  = PW'($urandom) | PW'(32'h0101_0101);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!sel_ready && n < 50) begin tick(); n++; end
      total++;
      if (sel_ready !== 1'b1) begin bad++; $display("FAIL wait_ready: sel_ready=%b want 1", sel_ready); end
   endtask

   task automatic accept(input int id);
      wait_ready();
      sel_valid = 1'b1;
      sel_id = SW'(id);
      tick();
      sel_valid = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total += 6;
      if (active_id !== '0) begin bad++; $display("FAIL rst_active_id: got %0d want 0", active_id); end
      if (sel_err !== 1'b0) begin bad++; $display("FAIL rst_sel_err: got %b want 0", sel_err); end
      if ({uo_out, uio_out, uio_oe} !== 24'h0) begin bad++; $display("FAIL rst_pads: got %h want 0", {uo_out, uio_out, uio_oe}); end
      if (proj_ena !== '0) begin bad++; $display("FAIL rst_proj_ena: got %b want 0", proj_ena); end
      if (proj_rst_n !== '0) begin bad++; $display("FAIL rst_proj_rst_n: got %b want 0", proj_rst_n); end
      @(negedge clk) rst_n = 1'b1;
      tick();
      if ({sel_ready, busy} !== 2'b10) begin bad++; $display("FAIL rst_ready_busy: got %b want 10", {sel_ready, busy}); end
   endtask

   // Checks every cycle from the accept edge until the first RUN cycle.
   task automatic test_select(input int id);
      accept(id);
      for (int k = 1; k <= RH + 2; k++) begin
         total += 4;
         if (proj_rst_n !== (k == RH + 2 ? onehot(id) : '0)) begin bad++; $display("FAIL sel_rst_n k=%0d: got %b want %b", k, proj_rst_n, (k == RH + 2 ? onehot(id) : NP'(0))); end
         if (proj_ena !== (k == 1 ? '0 : onehot(id))) begin bad++; $display("FAIL sel_ena k=%0d: got %b want %b", k, proj_ena, (k == 1 ? NP'(0) : onehot(id))); end
         if (busy !== (k <= RH + 1)) begin bad++; $display("FAIL sel_busy k=%0d: got %b want %b", k, busy, k <= RH + 1); end
         if ({uo_out, uio_oe} !== 16'h0) begin bad++; $display("FAIL sel_pads_off k=%0d: got %h want 0", k, {uo_out, uio_oe}); end
         shuffle();
         if (k <= RH + 1) tick();
      end
      total++;
      if (active_id !== SW'(id)) begin bad++; $display("FAIL sel_active_id: got %0d want %0d", active_id, id); end
      m_id = id;
   endtask

   task automatic test_traffic(input int n);
      logic [7:0] e_uo, e_uio, e_oe;
      for (int j = 0; j < n; j++) begin
         shuffle();
         e_uo = slice(proj_uo_out, m_id);
         e_uio = slice(proj_uio_out, m_id);
         e_oe = slice(proj_uio_oe, m_id);
         tick();
         total += 3;
         if (uo_out !== e_uo) begin bad++; $display("FAIL run_uo id=%0d: got %h want %h", m_id, uo_out, e_uo); end
         if (uio_out !== e_uio) begin bad++; $display("FAIL run_uio_out id=%0d: got %h want %h", m_id, uio_out, e_uio); end
         if (uio_oe !== e_oe) begin bad++; $display("FAIL run_uio_oe id=%0d: got %h want %h", m_id, uio_oe, e_oe); end
      end
   endtask

   task automatic test_bad_id(input int id);
      accept(id);
      total += 2;
      if (sel_err !== 1'b1) begin bad++; $display("FAIL bad_sel_err id=%0d: got %b want 1", id, sel_err); end
      if (busy !== 1'b1) begin bad++; $display("FAIL bad_drain_busy: got %b want 1", busy); end
      shuffle();
      tick();
      shuffle();
      tick();
      total += 5;
      if ({sel_ready, busy} !== 2'b10) begin bad++; $display("FAIL bad_idle: ready,busy got %b want 10", {sel_ready, busy}); end
      if (active_id !== SW'(id)) begin bad++; $display("FAIL bad_active_id: got %0d want %0d", active_id, id); end
      if (proj_ena !== '0 || proj_rst_n !== '0) begin bad++; $display("FAIL bad_proj_ctl: ena %b rst_n %b want 0", proj_ena, proj_rst_n); end
      if ({uo_out, uio_out, uio_oe} !== 24'h0) begin bad++; $display("FAIL bad_pads: got %h want 0", {uo_out, uio_out, uio_oe}); end
      ui_in = 8'hA5;
      #1;
      if (proj_ui_in !== (ISO ? '0 : {NP{8'hA5}})) begin bad++; $display("FAIL bad_iso_ui: got %h want %h", proj_ui_in, (ISO ? PW'(0) : {NP{8'hA5}})); end
      test_select(int'($urandom_range(0, NP - 1)));
      total++;
      if (sel_err !== 1'b0) begin bad++; $display("FAIL bad_err_clear: got %b want 0", sel_err); end
   endtask

   task automatic test_back_to_back(input int a, input int b);
      accept(a);
      sel_valid = 1'b1;
      sel_id = SW'(b);
      for (int k = 1; k <= RH + 2; k++) begin
         total++;
         if (sel_ready !== (k == RH + 2)) begin bad++; $display("FAIL b2b_ready k=%0d: got %b want %b", k, sel_ready, k == RH + 2); end
         if (k <= RH + 1) tick();
      end
      tick();
      sel_valid = 1'b0;
      total += 2;
      if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
      if (active_id !== SW'(b)) begin bad++; $display("FAIL b2b_active_id: got %0d want %0d", active_id, b); end
      wait_ready();
      total++;
      if (proj_rst_n !== onehot(b)) begin bad++; $display("FAIL b2b_rst_n: got %b want %b", proj_rst_n, onehot(b)); end
      m_id = b;
   endtask

   task automatic test_async_reset();
      accept(int'($urandom_range(0, NP - 1)));
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      total += 3;
      if (proj_ena !== '0 || proj_rst_n !== '0) begin bad++; $display("FAIL arst_hold_ctl: ena %b rst_n %b want 0", proj_ena, proj_rst_n); end
      if ({sel_ready, busy} !== 2'b10) begin bad++; $display("FAIL arst_hold_state: ready,busy got %b want 10", {sel_ready, busy}); end
      if (active_id !== '0) begin bad++; $display("FAIL arst_hold_id: got %0d want 0", active_id); end
      @(negedge clk) rst_n = 1'b1;
      test_select(3);
      test_traffic(2);
      #2 rst_n = 1'b0;
      #1;
      total += 2;
      if ({uo_out, uio_out, uio_oe} !== 24'h0) begin bad++; $display("FAIL arst_run_pads: got %h want 0", {uo_out, uio_out, uio_oe}); end
      if (proj_rst_n !== '0 || sel_err !== 1'b0) begin bad++; $display("FAIL arst_run_ctl: rst_n %b err %b want 0", proj_rst_n, sel_err); end
      @(negedge clk) rst_n = 1'b1;
      tick();
      total++;
      if (proj_rst_n !== '0) begin bad++; $display("FAIL arst_no_restore: got %b want 0", proj_rst_n); end
   endtask

   task automatic test_ena_drop();
      test_select(int'($urandom_range(0, NP - 1)));
      test_traffic(2);
      ena = 1'b0;
      #1;
      total += 2;
      if (proj_ena !== '0) begin bad++; $display("FAIL ena_drop: got %b want 0", proj_ena); end
      if (proj_rst_n !== onehot(m_id)) begin bad++; $display("FAIL ena_rst_n: got %b want %b", proj_rst_n, onehot(m_id)); end
      tick();
      total++;
      if ({sel_ready, busy} !== 2'b10) begin bad++; $display("FAIL ena_state: ready,busy got %b want 10", {sel_ready, busy}); end
      ena = 1'b1;
      #1;
      total++;
      if (proj_ena !== onehot(m_id)) begin bad++; $display("FAIL ena_restore: got %b want %b", proj_ena, onehot(m_id)); end
   endtask

   task automatic test_inputs();
      logic [7:0] r;
      ui_in = 8'hA5;
      r = 8'($urandom);
      uio_in = r;
      #1;
      for (int i = 0; i < NP; i++) begin
         total += 2;
         if (slice(proj_ui_in, i) !== ((ISO && i != m_id) ? 8'h00 : 8'hA5)) begin bad++; $display("FAIL in_ui slice %0d: got %h want %h", i, slice(proj_ui_in, i), ((ISO && i != m_id) ? 8'h00 : 8'hA5)); end
         if (slice(proj_uio_in, i) !== ((ISO && i != m_id) ? 8'h00 : r)) begin bad++; $display("FAIL in_uio slice %0d: got %h want %h", i, slice(proj_uio_in, i), ((ISO && i != m_id) ? 8'h00 : r)); end
      end
   endtask

   initial begin
      test_reset();
      test_select(2);
      test_traffic(4);
      test_select(1);
      test_traffic(3);
      for (int j = 0; j < 3; j++) begin
         test_select(int'($urandom_range(0, NP - 1)));
         test_traffic(3);
         test_inputs();
      end
      test_select(m_id);
      test_traffic(2);
      test_bad_id(7);
      test_traffic(2);
      test_bad_id(int'($urandom_range(NP, 15)));
      test_back_to_back(int'($urandom_range(0, NP - 1)), int'($urandom_range(0, NP - 1)));
      test_traffic(3);
      test_async_reset();
      test_ena_drop();
      test_inputs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/heichips25_proj_mux.md
# heichips25_proj_mux

Shares the tile's single set of pads (`ui_in`, `uo_out`, `uio_*`) between `NUM_PROJ` user projects built from the standard project template. It accepts a project-select command over a valid/ready port and sequences the hand-over: isolate, reset the new project, then connect it. It sits between the pad ring and the project instances, so exactly one project drives the pads at any time.

## Interface

Parameters:
- `NUM_PROJ`, default 4: number of attached projects (2..16).
- `SEL_W`, default 4: width of the project id.
- `RST_HOLD`, default 8: cycles the new project is held in reset (1..255).

Ports:
- `clk` in 1: single clock for the block and all projects.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: pad-level enable. Gates every `proj_ena` bit.
- `ui_in` in 8: pad dedicated inputs.
- `uo_out` out 8: pad dedicated outputs.
- `uio_in` in 8: pad bidirectional input path.
- `uio_out` out 8: pad bidirectional output path.
- `uio_oe` out 8: pad output enables (1 = output).
- `sel_valid` in 1: select command valid.
- `sel_id` in `SEL_W`: requested project id.
- `sel_ready` out 1: block can accept a command.
- `proj_ui_in` out `NUM_PROJ*8`: per-project `ui_in`; slice i is bits [8i+7:8i].
- `proj_uio_in` out `NUM_PROJ*8`: per-project `uio_in`.
- `proj_uo_out` in `NUM_PROJ*8`: per-project `uo_out`.
- `proj_uio_out` in `NUM_PROJ*8`: per-project `uio_out`.
- `proj_uio_oe` in `NUM_PROJ*8`: per-project `uio_oe`.
- `proj_ena` out `NUM_PROJ`: per-project enable.
- `proj_rst_n` out `NUM_PROJ`: per-project reset, active low.
- `active_id` out `SEL_W`: currently selected id.
- `busy` out 1: a hand-over is in progress.
- `sel_err` out 1: the last accepted id was out of range.

## Operation

FSM states and transitions:
- `IDLE`: no project is connected. On accept, go to `DRAIN`.
- `DRAIN`: lasts one cycle. Go to `HOLD` if the id is valid, otherwise go to `IDLE`.
- `HOLD`: lasts `RST_HOLD` cycles, then go to `RUN`.
- `RUN`: the selected project is connected. On accept, go to `DRAIN`.

Handshake:
- A command is accepted on a rising edge with `sel_valid && sel_ready`.
- `sel_ready` is 1 in `IDLE` and `RUN`, and 0 in `DRAIN` and `HOLD`.
- The requester holds `sel_valid`/`sel_id` stable until accepted.
- `busy` = state ∈ {`DRAIN`, `HOLD`}.

Accept behaviour:
- `sel_id` is latched into `active_id`.
- `sel_err` is set if `sel_id >= NUM_PROJ`, otherwise cleared.
- An invalid id ends in `IDLE` with `active_id` holding the latched value.
- Re-selecting the running id is legal and re-runs the full sequence. This is the per-project soft reset.

Per-project controls:
- `proj_ena[i] = ena & (i == active_id) & state ∈ {HOLD, RUN}`.
- `proj_rst_n[i]` = 1 only when `i == active_id` and state is `RUN`.
- Every non-selected project is held with `proj_ena` = 0 and `proj_rst_n` = 0.

Pad outputs:
- In `RUN`, `uo_out`/`uio_out`/`uio_oe` come from a registered copy of the selected project's slices.
- In all other states these registers load 0, so `uio_oe` = 0 and every pad is an input.
- Inputs `ui_in`/`uio_in` go to projects combinationally (see Configuration).

## Timing

Reset values (while `rst_n` = 0):
- State `IDLE`; `active_id` = 0; `sel_err` = 0.
- `uo_out`, `uio_out`, `uio_oe` all 0.
- `proj_ena` = 0 and `proj_rst_n` = 0 for all projects.
- `sel_ready` = 1 and `busy` = 0 after reset release.

Hand-over latency:
- Accept at edge N puts the block in `DRAIN` during cycle N+1.
- `HOLD` covers cycles N+2 .. N+1+`RST_HOLD`.
- `proj_rst_n` rises and `RUN` begins at cycle N+2+`RST_HOLD`.
- `sel_ready` returns to 1 in the same cycle `RUN` begins.

Other timing:
- Project output to pad: 1 cycle (registered).
- Pad input to project: 0 cycles.
- `ena` low in `RUN`: `proj_ena` drops combinationally; the FSM is unaffected.
- `rst_n` asserted mid-hand-over or mid-run: immediate asynchronous return to the reset values. The previous selection is not restored.
- `HOLD` counter: 8 bits, loaded with `RST_HOLD-1`, decrements to 0.

## Configuration

Macro `HEICHIPS25_PROJ_MUX_ISOLATE_EN`:
- Defined: `proj_ui_in`/`proj_uio_in` slice i equals the pad inputs only when `i == active_id` and state is `HOLD` or `RUN`, and is 0 otherwise. Unselected projects see constant-zero inputs, which cuts switching power.
- Undefined: the pad inputs are broadcast to every slice unconditionally.

## Structure

Shared package `heichips25_pkg`:
- FSM state enum: `IDLE`, `DRAIN`, `HOLD`, `RUN`.
- Pad width constant `PAD_W` = 8.
- Max-project constant = 16.

Sub-module:
- `heichips25_proj_mux_sel`, a parameterised one-of-N 8-bit slice selector.
- Instantiated three times: `uo`, `uio_out`, `uio_oe`.

## Test plan

1. Reset release, then select id 2 with `RST_HOLD` = 8 -> `proj_rst_n[2]` rises exactly 10 cycles after the accept edge. `uo_out` follows `proj_uo_out[23:16]` with 1-cycle lag. All other `proj_ena` bits stay 0.
2. In `RUN` on id 2, select id 1 -> `uio_oe` is 0 for cycles N+1..N+10. `proj_rst_n[2]` is 0 from N+1. Id 1 then drives the pads.
3. Select id 7 with `NUM_PROJ` = 4 -> `sel_err` = 1, state returns to `IDLE`, all pad outputs are 0. A following valid select clears `sel_err`.
4. Hold `sel_valid` high during `HOLD` -> `sel_ready` stays 0 and the command is accepted on the first `RUN` cycle.
5. Assert `rst_n` mid-`HOLD` -> all outputs reach their reset values without waiting for a clock edge. Drop `ena` in `RUN` -> `proj_ena` goes low and the state stays `RUN`.
6. With `HEICHIPS25_PROJ_MUX_ISOLATE_EN` defined, drive `ui_in` = 8'hA5 -> only the active slice sees 8'hA5 and the rest see 0. Undefined -> every slice sees 8'hA5.
